// File: rtl/processor_pkg.sv
// Shared constants for the processor: ISA encodings, FSM state codes,
// memory geometry, syscall codes and the immediate sign-extension helper.
package processor_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned DMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);
  localparam int unsigned DMEM_AW    = $clog2(DMEM_DEPTH);
  localparam int unsigned REG_AW     = $clog2(NREGS);

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_LW      = 6'b001000;
  localparam logic [5:0] OP_SW      = 6'b001001;
  localparam logic [5:0] OP_BEQ     = 6'b001010;
  localparam logic [5:0] OP_BNE     = 6'b001011;
  localparam logic [5:0] OP_SYSCALL = 6'b010101;

  // R-type function codes, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_OR  = 6'd3;
  localparam logic [5:0] FN_SLT = 6'd4;

  // Syscall dispatch: service number in $v0, argument starting at $a0
  localparam logic [REG_AW-1:0] REG_V0 = 5'd8;
  localparam logic [REG_AW-1:0] REG_A0 = 5'd10;
  localparam logic [XLEN-1:0] SYS_PRINT_INT = 32'd1;
  localparam logic [XLEN-1:0] SYS_EXIT      = 32'd2;
  localparam logic [XLEN-1:0] SYS_PRINT_STR = 32'd7;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational 32-bit ALU: add, sub, and, or, signed set-less-than.
module alu
  import processor_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Operation select with wraparound arithmetic; zero flag drives branches
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = XLEN'($signed(a) < $signed(b));
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/processor.sv
// Single-cycle teaching processor: load phase fills instruction/data
// memories, run phase executes one instruction per clock, done holds state.
// Optional build macro SYSCALL_PRINT_EN enables simulation output for the
// print syscalls (1 = signed integer in $a0, 7 = 16-char string $a0..$t3).
module processor
  import processor_pkg::*;
#(
  parameter bit auto = 1'b0
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_signal,
  input  logic [XLEN-1:0] new_instruction,
  input  logic            add_into,
  output logic            end_signal,
  output logic [XLEN-1:0] debug1,
  output logic [XLEN-1:0] debug2,
  output logic [XLEN-1:0] debug3,
  output logic [XLEN-1:0] debug4,
  output logic [XLEN-1:0] debug5,
  output logic [XLEN-1:0] debug6,
  output logic [XLEN-1:0] debug7
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] icount_q, icount_d;
  logic [XLEN-1:0] psize_q, psize_d;
  logic [XLEN-1:0] dsize_q, dsize_d;
  logic [XLEN-1:0] alu_last_q, alu_last_d;
  logic            end_q, end_d;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  logic [XLEN-1:0]    cur_word;
  logic [5:0]         opcode, funct;
  logic [REG_AW-1:0]  rs, rt, rd;
  logic [XLEN-1:0]    imm_sext, rs_val, rt_val;

  logic [XLEN-1:0]    alu_b, alu_result;
  alu_op_e            alu_op;
  logic               alu_zero, funct_ok;

  logic               rf_we;
  logic [REG_AW-1:0]  rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_waddr;
  logic [XLEN-1:0]    dmem_wdata;

  // Instruction fetch and field decode
  assign cur_word = imem[pc_q[IMEM_AW-1:0]];
  assign opcode   = cur_word[31:26];
  assign rs       = cur_word[25:21];
  assign rt       = cur_word[20:16];
  assign rd       = cur_word[15:11];
  assign funct    = cur_word[5:0];
  assign imm_sext = sign_ext16(cur_word[15:0]);
  assign rs_val   = (rs == '0) ? '0 : regs[rs];
  assign rt_val   = (rt == '0) ? '0 : regs[rt];

  // ALU operand and operation select
  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = imm_sext;
    funct_ok = 1'b1;
    if (opcode == OP_RTYPE) begin
      alu_b = rt_val;
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: funct_ok = 1'b0;
      endcase
    end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
      alu_b  = rt_val;
      alu_op = ALU_SUB;
    end
  end

  alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Next-state, program counter, counters and write enables
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    icount_d   = icount_q;
    psize_d    = psize_q;
    dsize_d    = dsize_q;
    alu_last_d = alu_last_q;
    end_d      = end_q;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = alu_result;
    imem_we    = 1'b0;
    imem_waddr = psize_q[IMEM_AW-1:0];
    dmem_we    = 1'b0;
    dmem_waddr = dsize_q[DMEM_AW-1:0];
    dmem_wdata = new_instruction;

    case (state_q)
      ST_LOAD: begin
        if (start_signal || auto) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else if (add_into) begin
          if (dsize_q < 32'(DMEM_DEPTH)) begin
            dmem_we = 1'b1;
            dsize_d = dsize_q + 32'd1;
          end
        end else if (psize_q < 32'(IMEM_DEPTH)) begin
          imem_we = 1'b1;
          psize_d = psize_q + 32'd1;
        end
      end

      ST_RUN: begin
        if (pc_q < psize_q) begin
          icount_d = icount_q + 32'd1;
          pc_d     = pc_q + 32'd1;
          case (opcode)
            OP_RTYPE: begin
              if (funct_ok) begin
                rf_we      = 1'b1;
                alu_last_d = alu_result;
              end
            end
            OP_ADDI: begin
              rf_we      = 1'b1;
              rf_waddr   = rt;
              alu_last_d = alu_result;
            end
            OP_LW: begin
              rf_we      = 1'b1;
              rf_waddr   = rt;
              rf_wdata   = dmem[alu_result[DMEM_AW-1:0]];
              alu_last_d = alu_result;
            end
            OP_SW: begin
              dmem_we    = 1'b1;
              dmem_waddr = alu_result[DMEM_AW-1:0];
              dmem_wdata = rt_val;
              alu_last_d = alu_result;
            end
            OP_BEQ: begin
              alu_last_d = alu_result;
              if (alu_zero) pc_d = pc_q + 32'd1 + imm_sext;
            end
            OP_BNE: begin
              alu_last_d = alu_result;
              if (!alu_zero) pc_d = pc_q + 32'd1 + imm_sext;
            end
            OP_J: pc_d = imm_sext;
            OP_SYSCALL: begin
              if (regs[REG_V0] == SYS_EXIT) begin
                state_d = ST_DONE;
                end_d   = 1'b1;
                pc_d    = pc_q;
              end
            end
            default: ;
          endcase
        end
        // Running off the end terminates on the same edge the PC leaves the program
        if (state_d == ST_RUN && pc_d >= psize_q) begin
          state_d = ST_DONE;
          end_d   = 1'b1;
        end
      end

      ST_DONE: ;

      default: state_d = ST_LOAD;
    endcase
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      pc_q       <= '0;
      icount_q   <= '0;
      psize_q    <= '0;
      dsize_q    <= '0;
      alu_last_q <= '0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      icount_q   <= icount_d;
      psize_q    <= psize_d;
      dsize_q    <= dsize_d;
      alu_last_q <= alu_last_d;
      end_q      <= end_d;
    end
  end

  // Register file; r0 writes are dropped so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rf_we && rf_waddr != '0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Memories keep their contents through reset; writes are blocked while it is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else begin
      if (imem_we) imem[imem_waddr] <= new_instruction;
      if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
    end
  end

`ifdef SYSCALL_PRINT_EN
  // Simulation console for the print syscalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (state_q == ST_RUN && pc_q < psize_q && opcode == OP_SYSCALL) begin
      if (regs[REG_V0] == SYS_PRINT_INT)
        $display("%0d", $signed(regs[REG_A0]));
      else if (regs[REG_V0] == SYS_PRINT_STR)
        $display("%s", {regs[10], regs[11], regs[12], regs[13]});
    end
  end
`else
  // Print syscalls fall through the decoder as plain no-ops
`endif

  assign end_signal = end_q;
  assign debug1     = icount_q;
  assign debug2     = pc_q;
  assign debug3     = psize_q;
  assign debug4     = (state_q == ST_LOAD) ? '0 : cur_word;
  assign debug5     = dsize_q;
  assign debug6     = 32'(state_q);
  assign debug7     = alu_last_q;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: ALU vector table with a result
// scoreboard, plus hand sequences for load, termination and reset cases.
module tb_processor;

  localparam logic [5:0] T_ADDI = 6'b000001;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_LW   = 6'b001000;
  localparam logic [5:0] T_SW   = 6'b001001;
  localparam logic [5:0] T_BNE  = 6'b001011;

  logic        clk;
  logic        reset;
  logic        start_signal;
  logic [31:0] new_instruction;
  logic        add_into;
  logic        end_signal;
  logic [31:0] debug1, debug2, debug3, debug4, debug5, debug6, debug7;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  processor #(.auto(1'b0)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_signal    (start_signal),
    .new_instruction (new_instruction),
    .add_into        (add_into),
    .end_signal      (end_signal),
    .debug1          (debug1),
    .debug2          (debug2),
    .debug3          (debug3),
    .debug4          (debug4),
    .debug5          (debug5),
    .debug6          (debug6),
    .debug7          (debug7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_sys();
    return {6'b010101, 26'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with no rising edge in between
  task automatic do_reset();
    reset           = 1'b0;
    start_signal    = 1'b0;
    add_into        = 1'b0;
    new_instruction = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Exactly one rising edge consumes the presented word
  task automatic load_word(input logic [31:0] w, input logic target);
    add_into        = target;
    new_instruction = w;
    @(negedge clk);
  endtask

  task automatic start_run();
    add_into     = 1'b0;
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!end_signal && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (!end_signal) begin
      n_fail++;
      $display("FAIL %s timeout: end_signal still 0 after %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  fn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc;
    logic [31:0] exp;

    vecs[0] = '{16'd5,    16'd7,    6'd0, 32'h0000_000C};
    vecs[1] = '{16'd5,    16'd7,    6'd1, 32'hFFFF_FFFE};
    vecs[2] = '{16'h00F0, 16'h0F3C, 6'd2, 32'h0000_0030};
    vecs[3] = '{16'h00F0, 16'h0F3C, 6'd3, 32'h0000_0FFC};
    vecs[4] = '{16'hFFFD, 16'd2,    6'd4, 32'h0000_0001};
    vecs[5] = '{16'd2,    16'hFFFD, 6'd4, 32'h0000_0000};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 6'd0, 32'h0000_FFFE};
    vecs[7] = '{16'd1,    16'h1234, 6'd9, 32'h0000_1234};
    vecs[8] = '{16'h8000, 16'd1,    6'd1, 32'hFFFF_7FFF};

    reset = 1'b0;
    start_signal = 1'b0;
    add_into = 1'b0;
    new_instruction = '0;
    @(negedge clk);
    do_reset();

    // Reset state and load-phase counters
    check("rst_debug1", debug1, 32'd0);
    check("rst_debug2", debug2, 32'd0);
    check("rst_debug3", debug3, 32'd0);
    check("rst_debug4", debug4, 32'd0);
    check("rst_debug5", debug5, 32'd0);
    check("rst_debug6", debug6, 32'd0);
    check("rst_debug7", debug7, 32'd0);
    check("rst_end", 32'(end_signal), 32'd0);
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b1);
    load_word(32'h3333_3333, 1'b0);
    load_word(32'h4444_4444, 1'b1);
    load_word(32'h5555_5555, 1'b0);
    check("load_psize", debug3, 32'd3);
    check("load_dsize", debug5, 32'd2);
    check("load_state", debug6, 32'd0);
    check("load_end", 32'(end_signal), 32'd0);

    // ALU vector table: r1=a, r2=b, r3 = r1 op r2; result tracked by scoreboard
    foreach (vecs[i]) begin
      do_reset();
      load_word(enc_i(T_ADDI, 5'd0, 5'd1, vecs[i].a), 1'b0);
      load_word(enc_i(T_ADDI, 5'd0, 5'd2, vecs[i].b), 1'b0);
      load_word(enc_r(5'd1, 5'd2, 5'd3, vecs[i].fn), 1'b0);
      sb_q.push_back(vecs[i].exp);
      start_run();
      wait_done($sformatf("vec%0d", i), 20, cyc);
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL vec%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        exp = sb_q.pop_front();
        check($sformatf("vec%0d_alu", i), debug7, exp);
      end
      check($sformatf("vec%0d_count", i), debug1, 32'd3);
      check($sformatf("vec%0d_pc", i), debug2, 32'd3);
    end

    // addi/lw then run off the end two cycles after the start edge
    do_reset();
    load_word(enc_i(T_ADDI, 5'd0, 5'd21, 16'd4), 1'b0);
    load_word(enc_i(T_LW, 5'd21, 5'd17, 16'd0), 1'b0);
    for (int i = 0; i < 5; i++) load_word((i == 4) ? 32'd10 : 32'd0, 1'b1);
    start_run();
    wait_done("lw", 20, cyc);
    check("lw_cycles", 32'(cyc), 32'd2);
    check("lw_r17", dut.regs[17], 32'd10);
    check("lw_addr", debug7, 32'd4);
    check("lw_state", debug6, 32'd2);

    // Counted loop with bne back-edge; print syscall is a no-op here
    do_reset();
    load_word(enc_i(T_ADDI, 5'd0, 5'd8, 16'd1), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd21, 16'd3), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd17, 16'd10), 1'b0);
    load_word(enc_r(5'd21, 5'd0, 5'd10, 6'd0), 1'b0);
    load_word(enc_sys(), 1'b0);
    load_word(enc_i(T_ADDI, 5'd21, 5'd21, 16'd1), 1'b0);
    load_word(enc_i(T_BNE, 5'd21, 5'd17, 16'hFFFC), 1'b0);
    start_run();
    wait_done("loop", 200, cyc);
    check("loop_count", debug1, 32'd31);
    check("loop_r21", dut.regs[21], 32'd10);
    check("loop_pc", debug2, 32'd7);
    check("loop_a0", dut.regs[10], 32'd9);

    // Syscall exit mid-program; DONE then ignores start and loads
    do_reset();
    load_word(enc_i(T_ADDI, 5'd0, 5'd8, 16'd2), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd5, 16'd7), 1'b0);
    load_word(enc_sys(), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd6, 16'd9), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd7, 16'd1), 1'b0);
    start_run();
    wait_done("exit", 20, cyc);
    check("exit_cycles", 32'(cyc), 32'd3);
    check("exit_pc", debug2, 32'd2);
    check("exit_count", debug1, 32'd3);
    check("exit_r5", dut.regs[5], 32'd7);
    check("exit_r6", dut.regs[6], 32'd0);
    start_signal    = 1'b1;
    add_into        = 1'b1;
    new_instruction = 32'hDEAD_BEEF;
    repeat (5) @(negedge clk);
    start_signal = 1'b0;
    add_into     = 1'b0;
    check("done_pc", debug2, 32'd2);
    check("done_count", debug1, 32'd3);
    check("done_dsize", debug5, 32'd0);
    check("done_psize", debug3, 32'd5);
    check("done_end", 32'(end_signal), 32'd1);
    check("done_state", debug6, 32'd2);

    // Negative arithmetic, r0 discard, data address wrap, unknown opcode
    do_reset();
    load_word(enc_i(T_ADDI, 5'd0, 5'd1, 16'hFFFF), 1'b0);
    load_word(enc_r(5'd1, 5'd1, 5'd2, 6'd0), 1'b0);
    load_word(enc_r(5'd1, 5'd0, 5'd3, 6'd4), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd0, 16'd5), 1'b0);
    load_word(enc_r(5'd0, 5'd0, 5'd4, 6'd0), 1'b0);
    load_word(enc_i(T_ADDI, 5'd0, 5'd9, 16'd77), 1'b0);
    load_word(enc_i(T_SW, 5'd0, 5'd9, 16'd260), 1'b0);
    load_word(enc_i(6'b111111, 5'd0, 5'd5, 16'd123), 1'b0);
    start_run();
    wait_done("arith", 30, cyc);
    check("arith_r2", dut.regs[2], 32'hFFFF_FFFE);
    check("arith_r3", dut.regs[3], 32'd1);
    check("arith_r0", dut.regs[0], 32'd0);
    check("arith_r4", dut.regs[4], 32'd0);
    check("arith_wrap", dut.dmem[4], 32'd77);
    check("arith_r5", dut.regs[5], 32'd0);
    check("arith_alu", debug7, 32'd260);
    check("arith_count", debug1, 32'd8);

    // Asynchronous reset in the middle of an endless loop
    do_reset();
    load_word(32'h0000_0011, 1'b1);
    load_word(32'h0000_0022, 1'b1);
    load_word(32'h0000_0033, 1'b1);
    load_word(enc_i(T_ADDI, 5'd1, 5'd1, 16'd1), 1'b0);
    load_word(enc_i(T_J, 5'd0, 5'd0, 16'd0), 1'b0);
    start_run();
    repeat (6) @(negedge clk);
    check("spin_end", 32'(end_signal), 32'd0);
    check("spin_state", debug6, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_pc", debug2, 32'd0);
    check("abort_state", debug6, 32'd0);
    check("abort_end", 32'(end_signal), 32'd0);
    check("abort_count", debug1, 32'd0);
    check("abort_dmem0", dut.dmem[0], 32'h11);
    check("abort_dmem2", dut.dmem[2], 32'h33);
    @(negedge clk);
    reset = 1'b1;
    load_word(32'h0000_0055, 1'b1);
    check("reload_dmem0", dut.dmem[0], 32'h55);
    check("reload_dmem1", dut.dmem[1], 32'h22);
    check("reload_dsize", debug5, 32'd1);

    // Data memory saturates at depth; extra loads are dropped
    do_reset();
    for (int i = 0; i < 258; i++) load_word(32'(i), 1'b1);
    check("sat_dsize", debug5, 32'd256);
    check("sat_dmem0", dut.dmem[0], 32'd0);
    check("sat_dmem255", dut.dmem[255], 32'd255);
    check("sat_state", debug6, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
